// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter_pkg
// Description : Shared constants, state encoding and helpers for the 4-way
//               round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux4_rr_arbiter_pkg;

    localparam int N_REQ        = 4;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_CNT_W    = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // One-hot grant vector for a requester index
    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter_pick
// Description : Combinational round-robin picker. Scans req starting one
//               past last_ptr and wraps, so last_ptr itself is checked last.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter_pick
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last_ptr,
    output logic             any,
    output logic [1:0]       win
);

    // Walk the priority order from lowest to highest so the nearest
    // requester after last_ptr is the one left standing in win.
    always_comb begin
        logic [1:0] idx;
        any = |req;
        win = 2'b00;
        idx = 2'b00;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last_ptr + 2'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter sharing one 4:1 word mux among four
//               requesters. Registered one-hot grant and mux select, grant
//               held until release by done, dropped request or hold timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       Op,
    output logic             sel_valid,
    output logic             new_grant
);

    localparam bit             HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);

    arb_state_t       state;
    logic [1:0]       last_ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [N_REQ-1:0] pick_req;
    logic             pick_any;
    logic [1:0]       pick_win;
    logic             timeout;
    logic             rel;

    // Current owner is excluded from the pick; gnt is zero when idle so the
    // same masking serves both the idle and the hand-over arbitration.
    assign pick_req  = req & ~gnt;
    assign timeout   = HOLD_EN && (hold_cnt == HOLD_LAST);
    assign rel       = done[Op] | ~req[Op] | timeout;
    assign sel_valid = |gnt;

    mux4_rr_arbiter_pick u_pick (
        .req      (pick_req),
        .last_ptr (last_ptr),
        .any      (pick_any),
        .win      (pick_win)
    );

    // Arbitration FSM with registered grant, select, pulse and hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            Op        <= 2'b00;
            new_grant <= 1'b0;
            last_ptr  <= 2'd3;
            hold_cnt  <= '0;
        end else begin
            new_grant <= 1'b0;
            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    if (pick_any) begin
                        gnt       <= onehot4(pick_win);
                        Op        <= pick_win;
                        last_ptr  <= pick_win;
                        new_grant <= 1'b1;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!rel) begin
                        if (HOLD_EN && (hold_cnt != HOLD_LAST)) begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end else if (pick_any) begin
                        // Hand over directly to the next waiting requester
                        gnt       <= onehot4(pick_win);
                        Op        <= pick_win;
                        last_ptr  <= pick_win;
                        new_grant <= 1'b1;
                        hold_cnt  <= '0;
                    end else if (req[Op]) begin
                        // Nobody else waiting: owner gets a fresh grant
                        new_grant <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        // Op keeps its value; it is meaningless while idle
                        gnt      <= '0;
                        hold_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Self-checking bench for mux4_rr_arbiter: directed vector
//               table, multi-cycle timeout/reset sequences and random
//               traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    localparam int MH = 4;
    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] gnt;
    logic [1:0] op;
    logic       sel_valid;
    logic       new_grant;

    int total = 0;
    int bad   = 0;

    mux4_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .Op        (op),
        .sel_valid (sel_valid),
        .new_grant (new_grant)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how many visible cycles,
    // and who was served last.
    int m_owner;
    int m_held;
    int m_last;
    int m_op;
    bit m_ng;

    function automatic void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 3;
        m_op    = 0;
        m_ng    = 0;
    endfunction

    function automatic int rr_pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_grant(input int p);
        m_owner = p;
        m_op    = p;
        m_last  = p;
        m_held  = 1;
        m_ng    = 1;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic [3:0] d);
        int  p;
        bit  release_now;
        logic [3:0] others;
        if (m_owner < 0) begin
            p = rr_pick(r);
            if (p >= 0) model_grant(p);
            else m_ng = 0;
        end else begin
            release_now = d[m_owner] || !r[m_owner] || (MH != 0 && m_held == MH);
            if (!release_now) begin
                m_held++;
                m_ng = 0;
            end else begin
                others = r;
                others[m_owner] = 1'b0;
                p = rr_pick(others);
                if (p >= 0) model_grant(p);
                else if (r[m_owner]) model_grant(m_owner);
                else begin
                    m_owner = -1;
                    m_ng    = 0;
                end
            end
        end
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int exp_gnt;
        exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
        check("model_gnt", int'(gnt), exp_gnt);
        check("model_op", int'(op), m_op);
        check("model_sel_valid", int'(sel_valid), (m_owner >= 0) ? 1 : 0);
        check("model_new_grant", int'(new_grant), int'(m_ng));
        check("inv_onehot0", ($countones(gnt) <= 1) ? 1 : 0, 1);
        check("inv_gnt_op", int'(gnt[op]), int'(sel_valid));
    endtask

    // Clock edge: model sees the same inputs the DUT samples
    task automatic step();
        @(posedge clk);
        model_step(req, done);
        #1;
        check_model();
    endtask

    task automatic reset_dut();
        req   = '0;
        done  = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] op;
        bit         ng;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Basic grant/release, full round-robin rotation, non-owner done
        tbl[0]  = '{1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1};
        tbl[1]  = '{0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0};
        tbl[2]  = '{1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1};
        tbl[3]  = '{0, 4'b1111, 4'b0001, 4'b0010, 2'd1, 1};
        tbl[4]  = '{0, 4'b1111, 4'b0010, 4'b0100, 2'd2, 1};
        tbl[5]  = '{0, 4'b1111, 4'b0100, 4'b1000, 2'd3, 1};
        tbl[6]  = '{0, 4'b1111, 4'b1000, 4'b0001, 2'd0, 1};
        tbl[7]  = '{0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0};
        tbl[8]  = '{0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1};
        tbl[9]  = '{0, 4'b0010, 4'b0100, 4'b0010, 2'd1, 0};
        tbl[10] = '{0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0};

        model_reset();
        reset_dut();
        check("reset_gnt", int'(gnt), 0);
        check("reset_op", int'(op), 0);
        check("reset_sel_valid", int'(sel_valid), 0);
        check("reset_new_grant", int'(new_grant), 0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) reset_dut();
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            check($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
            check($sformatf("tbl%0d_op", i), int'(op), int'(tbl[i].op));
            check($sformatf("tbl%0d_sel", i), int'(sel_valid), (tbl[i].gnt != 0) ? 1 : 0);
            check($sformatf("tbl%0d_ng", i), int'(new_grant), int'(tbl[i].ng));
        end

        // Timeout hand-over between two steady requesters: 4 cycles each
        reset_dut();
        req  = 4'b0011;
        done = 4'b0000;
        for (int c = 1; c <= 9; c++) begin
            step();
            check($sformatf("to2_gnt_c%0d", c), int'(gnt),
                  (c <= 4 || c == 9) ? 1 : 2);
            check($sformatf("to2_ng_c%0d", c), int'(new_grant),
                  (c == 1 || c == 5 || c == 9) ? 1 : 0);
        end

        // Lone requester: re-granted every 4 cycles without dropping gnt
        reset_dut();
        req = 4'b0100;
        for (int c = 1; c <= 13; c++) begin
            step();
            check($sformatf("regrant_gnt_c%0d", c), int'(gnt), 4);
            check($sformatf("regrant_ng_c%0d", c), int'(new_grant),
                  ((c - 1) % 4 == 0) ? 1 : 0);
        end

        // Asynchronous reset between edges while a grant is active
        reset_dut();
        req = 4'b0010;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_gnt", int'(gnt), 0);
        check("async_rst_op", int'(op), 0);
        check("async_rst_sel", int'(sel_valid), 0);
        req = 4'b1000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_gnt", int'(gnt), 8);
        check("post_rst_op", int'(op), 3);
        check("post_rst_ng", int'(new_grant), 1);

        // Random traffic against the model
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
            done = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'b0000;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
